trim_sweep_gen: RTL and testbench

- Parametrised successor to the fixed 12-bit trim-code generator.
- Sweeps a trim code over a programmable range and serialises each code on DOUT with a gated serial clock ENCLK, then a LATCH strobe and an inter-code gap.
- Adds single-sweep, continuous and manual-step modes, plus abort.
- Whole block runs on CLK50 with a tick enable; no derived or divided clocks.

---
 rtl/trim_sweep_gen.sv | 157 +++++++++++++++
 tb/tb_trim_sweep_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/trim_sweep_gen.sv
// trim_sweep_gen: sweeps a trim code over a range and serialises each code with gated clock and latch strobe
module trim_sweep_gen #(
  parameter int WIDTH     = 12,
  parameter int DIV       = 25000000,
  parameter int GAP_BITS  = 3,
  parameter int LSB_FIRST = 1
) (
  input  logic             CLK50,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] CODE_MIN,
  input  logic [WIDTH-1:0] CODE_MAX,
  output logic             DOUT,
  output logic             ENCLK,
  output logic             LATCH,
  output logic [WIDTH-1:0] TRIMCODE,
  output logic             BUSY,
  output logic             DONE
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(2 * GAP_BITS + 2);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_GAP, S_NEXT} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             phase_q, phase_d;
  logic [WIDTH-1:0] shift_q, shift_d, code_q, code_d, trim_q, trim_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, ptr_q, ptr_d;
  logic [1:0]       mode_q, mode_d;
  logic             dout_q, dout_d, enclk_q, enclk_d, latch_q, latch_d, done_q, done_d;
  logic             tick, bit_sel;
  logic [WIDTH-1:0] hi_in, code_wrap;
  logic [1:0]       mode_in;
  always_comb begin
    tick      = cnt_q == CW'(DIV - 1);
    hi_in     = CODE_MIN > CODE_MAX ? CODE_MIN : CODE_MAX;
    mode_in   = MODE == 2'd3 ? 2'd0 : MODE;
    code_wrap = code_q == hi_q ? lo_q : code_q + 1'b1;
    state_d   = state_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    phase_d   = phase_q;
    shift_d   = shift_q;
    code_d    = code_q;
    trim_d    = trim_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    ptr_d     = ptr_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: if (START) begin
        mode_d  = mode_in;
        lo_d    = CODE_MIN;
        hi_d    = hi_in;
        code_d  = (mode_in == 2'd2 && ptr_q >= CODE_MIN && ptr_q <= hi_in) ? ptr_q : CODE_MIN;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d = code_q;
        trim_d  = code_q;
        bit_d   = '0;
        phase_d = 1'b0;
        state_d = S_SHIFT;
      end
      S_SHIFT: if (tick) begin
        phase_d = !phase_q;
        if (phase_q) begin
          shift_d = LSB_FIRST != 0 ? shift_q >> 1 : shift_q << 1;
          bit_d   = bit_q + 1'b1;
          state_d = bit_q == BW'(WIDTH - 1) ? S_LATCH : S_SHIFT;
        end
      end
      S_LATCH: if (tick) begin
        gap_d   = '0;
        state_d = GAP_BITS == 0 ? S_NEXT : S_GAP;
      end
      S_GAP: if (tick) begin
        gap_d   = gap_q + 1'b1;
        state_d = gap_q == GW'(2 * GAP_BITS - 1) ? S_NEXT : S_GAP;
      end
      S_NEXT: begin
        if (mode_q == 2'd2) begin
          ptr_d   = code_wrap;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (mode_q == 2'd1) begin
          code_d  = code_wrap;
          state_d = S_LOAD;
        end else begin
          code_d  = code_q == hi_q ? code_q : code_q + 1'b1;
          done_d  = code_q == hi_q;
          state_d = code_q == hi_q ? S_IDLE : S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (ABORT) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      ptr_d   = ptr_q;
      trim_d  = trim_q;
    end
    cnt_d   = (state_q inside {S_SHIFT, S_LATCH, S_GAP} && state_d != S_IDLE && !tick) ? cnt_q + 1'b1 : '0;
    bit_sel = LSB_FIRST != 0 ? shift_d[0] : shift_d[WIDTH-1];
    dout_d  = state_d == S_SHIFT && bit_sel;
    enclk_d = state_d == S_SHIFT && phase_d;
    latch_d = state_d == S_LATCH;
  end
  always_ff @(posedge CLK50) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      phase_q <= 1'b0;
      shift_q <= '0;
      code_q  <= '0;
      trim_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      ptr_q   <= '0;
      mode_q  <= '0;
      dout_q  <= 1'b0;
      enclk_q <= 1'b0;
      latch_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      phase_q <= phase_d;
      shift_q <= shift_d;
      code_q  <= code_d;
      trim_q  <= trim_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      ptr_q   <= ptr_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
      enclk_q <= enclk_d;
      latch_q <= latch_d;
      done_q  <= done_d;
    end
  end
  assign DOUT     = dout_q;
  assign ENCLK    = enclk_q;
  assign LATCH    = latch_q;
  assign TRIMCODE = trim_q;
  assign BUSY     = state_q != S_IDLE;
  assign DONE     = done_q;
endmodule

// File: tb/tb_trim_sweep_gen.sv
// tb_trim_sweep_gen: directed bench driving an LSB-first and an MSB-first instance with shared stimulus
module tb_trim_sweep_gen;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] cmin = 4'd0, cmax = 4'd0;
  logic       dout[2], enclk[2], latch[2], busy[2], done[2];
  logic [3:0] trim[2];
  int         n_checks = 0, n_fail = 0, d0 = 0;
  logic [3:0] word[2];
  int         npulse[2] = '{0, 0}, nhigh[2] = '{0, 0}, ndone[2] = '{0, 0};
  logic       enclk_p[2] = '{1'b0, 1'b0}, latch_p[2] = '{1'b0, 1'b0};
  logic [3:0] log0[$], log1[$];
  always #5 clk = ~clk;
  trim_sweep_gen #(.WIDTH(4), .DIV(2), .GAP_BITS(1), .LSB_FIRST(1)) u_lsb (
    .CLK50(clk), .RST(rst), .START(start), .ABORT(abort), .MODE(mode), .CODE_MIN(cmin), .CODE_MAX(cmax),
    .DOUT(dout[0]), .ENCLK(enclk[0]), .LATCH(latch[0]), .TRIMCODE(trim[0]), .BUSY(busy[0]), .DONE(done[0]));
  trim_sweep_gen #(.WIDTH(4), .DIV(2), .GAP_BITS(1), .LSB_FIRST(0)) u_msb (
    .CLK50(clk), .RST(rst), .START(start), .ABORT(abort), .MODE(mode), .CODE_MIN(cmin), .CODE_MAX(cmax),
    .DOUT(dout[1]), .ENCLK(enclk[1]), .LATCH(latch[1]), .TRIMCODE(trim[1]), .BUSY(busy[1]), .DONE(done[1]));
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Rebuild each shifted word from DOUT at ENCLK rise; a word is logged at the LATCH rise.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (enclk[k] && !enclk_p[k]) begin
        word[k] = k == 0 ? {dout[k], word[k][3:1]} : {word[k][2:0], dout[k]};
        npulse[k]++;
      end
      if (enclk[k]) nhigh[k]++;
      if (latch[k] && !latch_p[k]) begin
        check(k == 0 ? "pulses_lsb" : "pulses_msb", npulse[k], 4);
        check(k == 0 ? "enclk_high_lsb" : "enclk_high_msb", nhigh[k], 8);
        if (k == 0) log0.push_back(word[k]);
        else log1.push_back(word[k]);
        npulse[k] = 0;
        nhigh[k]  = 0;
      end
      if (done[k]) ndone[k]++;
      if (!busy[k]) begin
        npulse[k] = 0;
        nhigh[k]  = 0;
      end
      enclk_p[k] = enclk[k];
      latch_p[k] = latch[k];
    end
  end
  task automatic go(input logic [1:0] m, input logic [3:0] lo, input logic [3:0] hi);
    @(negedge clk);
    mode = m; cmin = lo; cmax = hi;
    log0.delete(); log1.delete();
    d0 = ndone[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && ndone[0] == d0; i++) @(negedge clk);
    check("done_seen", int'(ndone[0] != d0), 1);
    check("busy_after", int'(busy[0] | busy[1]), 0);
  endtask
  task automatic check_seq(input string tag, input int n, input int first, input int lo, input int hi);
    int e = first;
    check({tag, "_n"}, log0.size(), n);
    check({tag, "_n_msb"}, log1.size(), n);
    for (int i = 0; i < n; i++) begin
      check(tag, i < log0.size() ? int'(log0[i]) : -1, e);
      check({tag, "_msb"}, i < log1.size() ? int'(log1[i]) : -1, e);
      e = e == hi ? lo : e + 1;
    end
  endtask
  task automatic check_idle_outs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_dout"}, int'(dout[k]), 0);
      check({tag, "_enclk"}, int'(enclk[k]), 0);
      check({tag, "_latch"}, int'(latch[k]), 0);
      check({tag, "_busy"}, int'(busy[k]), 0);
      check({tag, "_done"}, int'(done[k]), 0);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check_idle_outs("reset");
    check("reset_trim", int'(trim[0]), 0);
    rst = 1'b0;
    go(2'd0, 4'd5, 4'd7);
    wait_done(200);
    check_seq("t1", 3, 5, 5, 7);
    check("t1_done", ndone[0] - d0, 1);
    check("t1_done_msb", ndone[1] - d0, 1);
    go(2'd0, 4'd9, 4'd9);
    wait_done(100);
    check_seq("t2", 1, 9, 9, 9);
    check("t2_done", ndone[1] - d0, 1);
    go(2'd1, 4'd14, 4'd15);
    for (int i = 0; i < 300 && log0.size() < 4; i++) @(negedge clk);
    check_seq("t3", 4, 14, 14, 15);
    check("t3_nodone", ndone[0] - d0, 0);
    for (int i = 0; i < 50 && !enclk[0]; i++) @(negedge clk);
    check("t3_in_shift", int'(enclk[0]), 1);
    abort = 1'b1;
    @(negedge clk);
    check_idle_outs("t3_abort");
    check("t3_trim", int'(trim[0]), 14);
    check("t3_trim_msb", int'(trim[1]), 14);
    abort = 1'b0;
    repeat (30) @(negedge clk);
    check("t3_abort_nodone", ndone[0] - d0, 0);
    check("t3_stay_idle", int'(busy[0]), 0);
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      go(2'd2, 4'd2, 4'd3);
      wait_done(100);
      check_seq("t4", 1, j % 2 == 0 ? 2 : 3, 2, 3);
      check("t4_done", ndone[0] - d0, 1);
    end
    go(2'd0, 4'd10, 4'd3);
    wait_done(100);
    check_seq("t5a", 1, 10, 10, 10);
    go(2'd0, 4'd0, 4'd15);
    wait_done(800);
    check_seq("t5b", 16, 0, 0, 15);
    check("t5b_done", ndone[0] - d0, 1);
    go(2'd0, 4'd1, 4'd3);
    repeat (10) @(negedge clk);
    cmax = 4'd1; mode = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    check_seq("t6", 3, 1, 1, 3);
    check("t6_done", ndone[0] - d0, 1);
    go(2'd0, 4'd4, 4'd6);
    for (int i = 0; i < 50 && !latch[0]; i++) @(negedge clk);
    check("t6_latch_seen", int'(latch[0]), 1);
    for (int i = 0; i < 10 && latch[0]; i++) @(negedge clk);
    check("t6_trim_pre", int'(trim[0]), 4);
    check("t6_in_gap", int'(busy[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outs("t6_rst");
    check("t6_rst_trim", int'(trim[0]), 0);
    check("t6_rst_trim_msb", int'(trim[1]), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
